sprite_hit_compare: RTL and testbench
=====================================

# sprite_hit_compare

Pixel-rate comparator bank directly upstream of the comparator-stage register select mux. Holds 31 sprite entry registers. For every presented pixel coordinate it produces a registered hit vector: bit k-1 set means entry k covers that pixel. The downstream priority mux uses this vector to choose which entry's register is forwarded to the renderer. The entry registers are also exported so they can drive the mux data inputs.

## Interface
- `SIZE_REG`, default 32: width of each entry register and of `result`.
- `SPRITE_SIZE`, default 20: sprite edge length in pixels; valid range 1..512.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `wr_en` input, 1 bit: entry write strobe.
- `wr_addr` input, 5 bits: entry index, 1..31. Index 0 is ignored.
- `wr_data` input, `SIZE_REG` bits: entry word.
  - [9:0] x origin
  - [19:10] y origin
  - [29] active
  - all other bits are stored but not interpreted
- `frame_start` input, 1 bit: one-cycle pulse at the start of each frame.
- `pixel_valid` input, 1 bit: pixel coordinate is present this cycle.
- `pixel_x` input, 10 bits: pixel column.
- `pixel_y` input, 10 bits: pixel row.
- `r1`..`r31` output, `SIZE_REG` bits each: live (committed) entry registers.
- `result` output, `SIZE_REG` bits: hit vector. Bit k-1 corresponds to entry k. Bit 31 is always 0.
- `result_valid` output, 1 bit: `result` corresponds to a valid pixel.
- `hit_any` output, 1 bit: OR of `result[30:0]`, qualified by `result_valid`.

## Operation
- **Reset:**
  - all entry registers (and shadow registers, if compiled in) = 0, i.e. inactive
  - `result` = 0, `result_valid` = 0, `hit_any` = 0
  - pipeline contents are discarded
- **Write:**
  - `wr_en` with `wr_addr` in 1..31 loads `wr_data` into entry `wr_addr` on the clock edge.
  - `wr_addr` = 0 is a no-op.
- **Hit test for entry k:**
  - Condition: active AND `pixel_x` ≥ x AND (`pixel_x` − x) < `SPRITE_SIZE` AND `pixel_y` ≥ y AND (`pixel_y` − y) < `SPRITE_SIZE`.
  - Subtraction is performed at 11 bits.
  - Sprites near the 1023 edge are clipped; there is no wrap-around to coordinate 0.
- **Multiple hits:** multiple bits may be set simultaneously. Priority is resolved downstream, with the lowest index winning.
- **Pipeline, 2 stages:**
  - Stage 1 registers the per-entry x-in-range and y-in-range flags, together with `pixel_valid`.
  - Stage 2 registers `result` = AND of the flags with active.
  - When `pixel_valid` = 0, stage 2 loads `result` = 0 and deasserts `result_valid`.
- **Reset mid-frame:** outputs are forced to 0 immediately (asynchronously). Operation resumes with the first pixel presented after reset is released.

## Timing
- **Latency:** pixel presented at cycle N appears on `result` / `result_valid` at cycle N+2. Throughput is one pixel per cycle with no stalls.
- **Write vs. compare:** a write at cycle N affects pixels presented at cycle N+1 and later. Pixels at cycle N and earlier use the old value.
- **`r1`..`r31`:** update on the clock edge following the write, or the commit when shadowing is enabled.
- **Simultaneous `wr_en` and `frame_start`** (shadow build only): the write is included in that same commit.

## Configuration
- **`SPRITE_SHADOW_EN` defined:**
  - Writes go to 31 shadow registers.
  - On `frame_start`, all shadow registers are copied into the live entries at once.
  - Live entries, `r1`..`r31`, and compares change only at frame boundaries, so no tearing occurs.
- **`SPRITE_SHADOW_EN` undefined:**
  - No shadow registers are built.
  - Writes update the live entries directly, per the write-vs-compare rule above.
  - `frame_start` is ignored.

## Test plan
- **Reset state:** assert `reset` mid-stream → `result` = 0, `result_valid` = 0 and `r1`..`r31` = 0 in the same cycle. After release, a pixel at (5,5) returns `result` = 0 with `result_valid` = 1 two cycles later.
- **Single hit with edge bounds:**
  - Setup: entry 3 = {active, x=100, y=50}, `SPRITE_SIZE` = 20.
  - (100,50) → `result` = 32'h4 at N+2.
  - (119,69) → `result` = 32'h4.
  - (120,50) → 0.
  - (99,50) → 0.
- **Overlap:**
  - Setup: entries 1 and 31, both active at x=0, y=0.
  - (0,0) → `result` = 32'h4000_0001, `hit_any` = 1.
  - Setting entry 1 inactive → `result` = 32'h4000_0000.
- **Clipping:**
  - Setup: entry 2 active at x=1020, y=0.
  - (1023,0) → 32'h2.
  - (2,0) → 0, i.e. no wrap-around.
- **Write ordering:**
  - Non-shadow build: `wr_en` to entry 5 at cycle N with the pixel inside the new position at N → miss. The same pixel at N+1 → `result` = 32'h10.
  - Shadow build: hit appears only after the next `frame_start`. A write coincident with `frame_start` is live on the following cycle.
- **Idle and ignored writes:**
  - `pixel_valid` = 0 → `result_valid` = 0 and `result` = 0 two cycles later.
  - Write to `wr_addr` 0 → no entry changes.

Source files
------------

// File: rtl/sprite_hit_compare.sv
// ============================================================================
// sprite_hit_compare
// ----------------------------------------------------------------------------
// Pixel-rate comparator bank feeding the comparator-stage register select
// mux. Holds 31 sprite entry registers. For every presented pixel coordinate
// it produces a registered hit vector: bit k-1 set means entry k covers the
// pixel. The entry registers are exported to drive the mux data inputs.
//
// Entry word layout: [9:0] x origin, [19:10] y origin, [29] active. All other
// bits are stored and exported but not interpreted.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   wr_en         entry write strobe
//   wr_addr       entry index 1..31 (0 is ignored)
//   wr_data       entry word
//   frame_start   one-cycle pulse at frame start (used by the shadow build only)
//   pixel_valid   pixel coordinate present this cycle
//   pixel_x/y     pixel column / row
//   r1..r31       live (committed) entry registers
//   result        hit vector, bit k-1 = entry k, bits 31 and up always 0
//   result_valid  result corresponds to a valid pixel
//   hit_any       OR of result[30:0], qualified by result_valid
//
// Build option:
//   SPRITE_SHADOW_EN  when defined, writes land in shadow registers and are
//                     copied to the live entries on frame_start, so the
//                     compares never see a half-updated sprite list.
//
// Pipeline: pixel at cycle N -> result at cycle N+2, one pixel per cycle.
// SIZE_REG must be at least 32 (the active bit lives at [29] and the hit
// vector occupies 31 bits plus a zero bit 31).
// ============================================================================
module sprite_hit_compare #(
    parameter int SIZE_REG    = 32,
    parameter int SPRITE_SIZE = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [4:0]          wr_addr,
    input  logic [SIZE_REG-1:0] wr_data,
    input  logic                frame_start,
    input  logic                pixel_valid,
    input  logic [9:0]          pixel_x,
    input  logic [9:0]          pixel_y,
    output logic [SIZE_REG-1:0] r1,
    output logic [SIZE_REG-1:0] r2,
    output logic [SIZE_REG-1:0] r3,
    output logic [SIZE_REG-1:0] r4,
    output logic [SIZE_REG-1:0] r5,
    output logic [SIZE_REG-1:0] r6,
    output logic [SIZE_REG-1:0] r7,
    output logic [SIZE_REG-1:0] r8,
    output logic [SIZE_REG-1:0] r9,
    output logic [SIZE_REG-1:0] r10,
    output logic [SIZE_REG-1:0] r11,
    output logic [SIZE_REG-1:0] r12,
    output logic [SIZE_REG-1:0] r13,
    output logic [SIZE_REG-1:0] r14,
    output logic [SIZE_REG-1:0] r15,
    output logic [SIZE_REG-1:0] r16,
    output logic [SIZE_REG-1:0] r17,
    output logic [SIZE_REG-1:0] r18,
    output logic [SIZE_REG-1:0] r19,
    output logic [SIZE_REG-1:0] r20,
    output logic [SIZE_REG-1:0] r21,
    output logic [SIZE_REG-1:0] r22,
    output logic [SIZE_REG-1:0] r23,
    output logic [SIZE_REG-1:0] r24,
    output logic [SIZE_REG-1:0] r25,
    output logic [SIZE_REG-1:0] r26,
    output logic [SIZE_REG-1:0] r27,
    output logic [SIZE_REG-1:0] r28,
    output logic [SIZE_REG-1:0] r29,
    output logic [SIZE_REG-1:0] r30,
    output logic [SIZE_REG-1:0] r31,
    output logic [SIZE_REG-1:0] result,
    output logic                result_valid,
    output logic                hit_any
);

    localparam int         N_ENT  = 31;
    // Range limit at the 11-bit subtraction width.
    localparam logic [10:0] C_SIZE = 11'(SPRITE_SIZE);

    // Live entry registers, indexed 1..31 to match wr_addr.
    logic [SIZE_REG-1:0] r_entry [1:N_ENT];

    // Stage 1 flags (bit k-1 = entry k) and pixel qualifier.
    logic [N_ENT-1:0] r_s1_x_in;
    logic [N_ENT-1:0] r_s1_y_in;
    logic [N_ENT-1:0] r_s1_act;
    logic             r_s1_valid;

    // Stage 2 output registers.
    logic [SIZE_REG-1:0] r_result;
    logic                r_result_valid;
    logic                r_hit_any;

    // Combinational per-entry compare results.
    logic [N_ENT-1:0] w_x_in;
    logic [N_ENT-1:0] w_y_in;
    logic [N_ENT-1:0] w_act;
    logic [N_ENT-1:0] w_hits;

`ifdef SPRITE_SHADOW_EN
    // Shadow copies written by the host; committed to live entries per frame.
    logic [SIZE_REG-1:0] r_shadow [1:N_ENT];

    for (genvar k = 1; k <= N_ENT; k++) begin : g_shadow
        logic w_sel;
        assign w_sel = wr_en & (wr_addr == 5'(k));

        // Host write into the shadow register for this entry.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_shadow[k] <= '0;
            end else if (w_sel) begin
                r_shadow[k] <= wr_data;
            end
        end

        // Frame commit; a write coinciding with frame_start is folded in so
        // it goes live together with the rest of the frame's updates.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_entry[k] <= '0;
            end else if (frame_start) begin
                r_entry[k] <= w_sel ? wr_data : r_shadow[k];
            end
        end
    end
`else
    // frame_start has no role without shadowing; tie it off visibly.
    logic w_unused_frame_start;
    assign w_unused_frame_start = frame_start;

    for (genvar k = 1; k <= N_ENT; k++) begin : g_direct
        // Host write directly into the live entry register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_entry[k] <= '0;
            end else if (wr_en && (wr_addr == 5'(k))) begin
                r_entry[k] <= wr_data;
            end
        end
    end
`endif

    // Range compare for every entry. Operands are zero-extended to 11 bits;
    // bit 10 of the difference is the borrow, i.e. pixel < origin. Because
    // nothing wraps modulo 1024, sprites near coordinate 1023 are clipped.
    for (genvar k = 1; k <= N_ENT; k++) begin : g_cmp
        logic [10:0] w_dx;
        logic [10:0] w_dy;
        assign w_dx = {1'b0, pixel_x} - {1'b0, r_entry[k][9:0]};
        assign w_dy = {1'b0, pixel_y} - {1'b0, r_entry[k][19:10]};
        assign w_x_in[k-1] = ~w_dx[10] & (w_dx < C_SIZE);
        assign w_y_in[k-1] = ~w_dy[10] & (w_dy < C_SIZE);
        // Active is captured with the flags so one pixel always sees a
        // consistent snapshot of the entry, even if it is rewritten next cycle.
        assign w_act[k-1]  = r_entry[k][29];
    end

    // Stage 1: capture range flags, active bits and pixel qualifier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_x_in  <= '0;
            r_s1_y_in  <= '0;
            r_s1_act   <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_x_in  <= w_x_in;
            r_s1_y_in  <= w_y_in;
            r_s1_act   <= w_act;
            r_s1_valid <= pixel_valid;
        end
    end

    assign w_hits = r_s1_x_in & r_s1_y_in & r_s1_act;

    // Stage 2: form the hit vector; idle cycles present an all-zero result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_hit_any      <= 1'b0;
        end else if (r_s1_valid) begin
            r_result       <= {{(SIZE_REG-N_ENT){1'b0}}, w_hits};
            r_result_valid <= 1'b1;
            r_hit_any      <= |w_hits;
        end else begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_hit_any      <= 1'b0;
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign hit_any      = r_hit_any;

    assign r1  = r_entry[1];
    assign r2  = r_entry[2];
    assign r3  = r_entry[3];
    assign r4  = r_entry[4];
    assign r5  = r_entry[5];
    assign r6  = r_entry[6];
    assign r7  = r_entry[7];
    assign r8  = r_entry[8];
    assign r9  = r_entry[9];
    assign r10 = r_entry[10];
    assign r11 = r_entry[11];
    assign r12 = r_entry[12];
    assign r13 = r_entry[13];
    assign r14 = r_entry[14];
    assign r15 = r_entry[15];
    assign r16 = r_entry[16];
    assign r17 = r_entry[17];
    assign r18 = r_entry[18];
    assign r19 = r_entry[19];
    assign r20 = r_entry[20];
    assign r21 = r_entry[21];
    assign r22 = r_entry[22];
    assign r23 = r_entry[23];
    assign r24 = r_entry[24];
    assign r25 = r_entry[25];
    assign r26 = r_entry[26];
    assign r27 = r_entry[27];
    assign r28 = r_entry[28];
    assign r29 = r_entry[29];
    assign r30 = r_entry[30];
    assign r31 = r_entry[31];

endmodule

// File: tb/tb_sprite_hit_compare.sv
// Self-checking bench for sprite_hit_compare (default, non-shadow build).
// Directed table of spec scenarios, a mid-stream reset sequence, then
// randomized traffic checked against a coordinate-level reference model.
module tb_sprite_hit_compare;

    localparam int SR = 32;
    localparam int SS = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [SR-1:0] wr_data;
    logic          frame_start;
    logic          pixel_valid;
    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic [SR-1:0] r_out [1:31];
    logic [SR-1:0] result;
    logic          result_valid;
    logic          hit_any;

    int checks = 0;
    int errors = 0;

    // Reference state: entry contents as the specification defines them.
    logic [31:0] model [1:31];

    typedef struct {
        logic [31:0] r;
        bit          v;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          pv;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [31:0] er;
        bit          ev;
    } vec_t;
    vec_t tbl[$];

    sprite_hit_compare #(.SIZE_REG(SR), .SPRITE_SIZE(SS)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_start(frame_start),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .r1(r_out[1]),   .r2(r_out[2]),   .r3(r_out[3]),   .r4(r_out[4]),
        .r5(r_out[5]),   .r6(r_out[6]),   .r7(r_out[7]),   .r8(r_out[8]),
        .r9(r_out[9]),   .r10(r_out[10]), .r11(r_out[11]), .r12(r_out[12]),
        .r13(r_out[13]), .r14(r_out[14]), .r15(r_out[15]), .r16(r_out[16]),
        .r17(r_out[17]), .r18(r_out[18]), .r19(r_out[19]), .r20(r_out[20]),
        .r21(r_out[21]), .r22(r_out[22]), .r23(r_out[23]), .r24(r_out[24]),
        .r25(r_out[25]), .r26(r_out[26]), .r27(r_out[27]), .r28(r_out[28]),
        .r29(r_out[29]), .r30(r_out[30]), .r31(r_out[31]),
        .result(result), .result_valid(result_valid), .hit_any(hit_any)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input bit act, input int x, input int y);
        logic [31:0] w;
        w        = 32'h0;
        w[29]    = act;
        w[9:0]   = 10'(x);
        w[19:10] = 10'(y);
        return w;
    endfunction

    // Hit vector from the coverage rule, evaluated with integer arithmetic.
    function automatic logic [31:0] model_result(input bit pv, input int px, input int py);
        logic [31:0] r;
        int ex;
        int ey;
        r = 32'h0;
        if (pv) begin
            for (int k = 1; k <= 31; k++) begin
                ex = int'(model[k][9:0]);
                ey = int'(model[k][19:10]);
                if (model[k][29] && px >= ex && (px - ex) < SS &&
                    py >= ey && (py - ey) < SS)
                    r[k-1] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic check_regs(input string name);
        int bad;
        bad = 0;
        for (int k = 1; k <= 31; k++)
            if (r_out[k] !== model[k] && bad == 0) bad = k;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s r%0d got=%h expected=%h", name, bad, r_out[bad], model[bad]);
        end
    endtask

    // One cycle; called at posedge+1. Checks the result due now, checks the
    // exported registers, drives this cycle's inputs, records the expectation.
    task automatic step(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit pv, input logic [9:0] px, input logic [9:0] py,
                        input logic [31:0] er, input bit ev);
        exp_t e;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            chk("result", result, e.r);
            chk("result_valid", {31'h0, result_valid}, {31'h0, e.v});
            chk("hit_any", {31'h0, hit_any}, {31'h0, (e.v && (|e.r[30:0]))});
        end
        check_regs("regs");
        wr_en       = we;
        wr_addr     = wa;
        wr_data     = wd;
        pixel_valid = pv;
        pixel_x     = px;
        pixel_y     = py;
        e.r = er;
        e.v = ev;
        exp_q.push_back(e);
        if (we && wa != 5'd0) model[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit we, input int wa, input logic [31:0] wd, input bit pv,
                       input int px, input int py, input logic [31:0] er, input bit ev);
        vec_t v;
        v.we = we; v.wa = 5'(wa); v.wd = wd; v.pv = pv;
        v.px = 10'(px); v.py = 10'(py); v.er = er; v.ev = ev;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] wd;
        logic [31:0] er;
        int          base;
        int          pbase;
        bit          we;
        bit          pv;
        logic [4:0]  wa;
        logic [9:0]  px;
        logic [9:0]  py;

        // Directed table: each row is one cycle; expectation is for that pixel.
        add(1, 3, mk(1, 100, 50), 0, 0, 0, 32'h0, 0);
        add(0, 0, 32'h0, 1, 100, 50, 32'h4, 1);
        add(0, 0, 32'h0, 1, 119, 69, 32'h4, 1);
        add(0, 0, 32'h0, 1, 120, 50, 32'h0, 1);
        add(0, 0, 32'h0, 1, 99, 50, 32'h0, 1);
        add(0, 0, 32'h0, 1, 119, 70, 32'h0, 1);
        add(1, 1, mk(1, 0, 0), 1, 0, 0, 32'h0, 1);
        add(1, 31, mk(1, 0, 0), 1, 0, 0, 32'h1, 1);
        add(0, 0, 32'h0, 1, 0, 0, 32'h4000_0001, 1);
        add(1, 1, mk(0, 0, 0), 1, 0, 0, 32'h4000_0001, 1);
        add(0, 0, 32'h0, 1, 0, 0, 32'h4000_0000, 1);
        add(1, 2, mk(1, 1020, 0), 1, 1023, 0, 32'h0, 1);
        add(1, 31, mk(0, 0, 0), 1, 1023, 0, 32'h2, 1);
        add(0, 0, 32'h0, 1, 2, 0, 32'h0, 1);
        add(0, 0, 32'h0, 1, 1020, 19, 32'h2, 1);
        add(1, 5, mk(1, 300, 300), 1, 305, 305, 32'h0, 1);
        add(0, 0, 32'h0, 1, 305, 305, 32'h10, 1);
        add(0, 0, 32'h0, 0, 305, 305, 32'h0, 0);
        add(1, 0, mk(1, 600, 600), 1, 305, 305, 32'h10, 1);
        add(0, 0, 32'h0, 1, 600, 600, 32'h0, 1);
        add(0, 0, 32'h0, 1, 319, 319, 32'h10, 1);
        add(0, 0, 32'h0, 1, 320, 300, 32'h0, 1);

        for (int k = 1; k <= 31; k++) model[k] = 32'h0;
        reset = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
        frame_start = 1'b0; pixel_valid = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 32'h0);
        chk("reset_valid", {31'h0, result_valid}, 32'h0);
        chk("reset_hit_any", {31'h0, hit_any}, 32'h0);
        check_regs("reset_regs");
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].pv, tbl[i].px, tbl[i].py,
                 tbl[i].er, tbl[i].ev);

        // Mid-stream reset while hits are in flight.
        step(0, 5'd0, 32'h0, 1, 10'd305, 10'd305, 32'h10, 1);
        step(0, 5'd0, 32'h0, 1, 10'd306, 10'd306, 32'h10, 1);
        #3;
        reset = 1'b1;
        #1;
        for (int k = 1; k <= 31; k++) model[k] = 32'h0;
        exp_q.delete();
        chk("midreset_result", result, 32'h0);
        chk("midreset_valid", {31'h0, result_valid}, 32'h0);
        chk("midreset_hit_any", {31'h0, hit_any}, 32'h0);
        check_regs("midreset_regs");
        pixel_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 5'd0, 32'h0, 1, 10'd5, 10'd5, 32'h0, 1);
        step(0, 5'd0, 32'h0, 0, 10'd0, 10'd0, 32'h0, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            we = ($urandom_range(0, 3) == 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            base = ($urandom_range(0, 3) == 0) ? 990 : 0;
            wd[9:0]   = 10'(base + $urandom_range(0, 33));
            base = ($urandom_range(0, 3) == 0) ? 990 : 0;
            wd[19:10] = 10'(base + $urandom_range(0, 33));
            wd[29]    = ($urandom_range(0, 4) != 0);
            pv = ($urandom_range(0, 7) != 0);
            pbase = ($urandom_range(0, 3) == 0) ? 990 : 0;
            px = 10'(pbase + $urandom_range(0, 33));
            pbase = ($urandom_range(0, 3) == 0) ? 990 : 0;
            py = 10'(pbase + $urandom_range(0, 33));
            er = model_result(pv, int'(px), int'(py));
            step(we, wa, wd, pv, px, py, er, pv);
        end

        // Drain the pipeline.
        step(0, 5'd0, 32'h0, 0, 10'd0, 10'd0, 32'h0, 0);
        step(0, 5'd0, 32'h0, 0, 10'd0, 10'd0, 32'h0, 0);
        step(0, 5'd0, 32'h0, 0, 10'd0, 10'd0, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
